adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Synthesizable response checker for the full-adder stimulus sequence: it consumes each applied vector {a,b,cin} together with the adder's {sum,cout}, recomputes the expected result, and accumulates pass/fail statistics. It sits at the output end of the adder test path, opposite the stimulus generator. It lets a sweep be checked on silicon or in an FPGA without a simulator.

## Interface
- WIDTH, 1, operand width of a and b; vector index width VW = 2*WIDTH+1; N_VEC = 2^VW
- CNT_W, 8, width of the error counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin (or restart) a check run
- in_valid  input  1  a/b/cin/dut_sum/dut_cout valid this cycle
- in_a  input  WIDTH  applied operand a
- in_b  input  WIDTH  applied operand b
- in_cin  input  1  applied carry-in
- dut_sum  input  WIDTH  adder sum output
- dut_cout  input  1  adder carry output
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  done, zero errors, no sequence error
- err_count  output  CNT_W  mismatching vectors, saturating
- seq_err  output  1  sticky: a vector arrived out of order
- first_fail_valid  output  1  first_fail_idx holds a captured vector
- first_fail_idx  output  VW  {a,b,cin} of the first mismatch

## Operation
- One clock and one reset: rst_n is asynchronous and active-low. Assertion forces IDLE and clears every register and output to 0, including a reset mid-run. Release is synchronous to clk.
- States are IDLE, RUN and DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the vector with vec_cnt = N_VEC-1 is accepted.
  - DONE -> RUN on start.
  - start while in RUN restarts the run.
- Any start that enters or restarts RUN clears err_count, seq_err, first_fail_valid, first_fail_idx and vec_cnt in the same edge.
- In RUN, each cycle with in_valid = 1 accepts one vector. in_valid is ignored in IDLE and DONE. start has priority over in_valid in the same cycle: the vector is dropped.
- Expected result is {exp_cout, exp_sum} = in_a + in_b + in_cin, computed at WIDTH+1 bits with no truncation. A mismatch is {dut_cout, dut_sum} != expected.
- Index is idx = {in_a, in_b, in_cin}, with a in the MSBs and cin in the LSB. Vectors must arrive in ascending order 0..N_VEC-1.
  - If idx != vec_cnt, seq_err sets and stays set until start or reset.
  - The vector is still value-checked.
  - vec_cnt increments regardless of the order check.
- On a mismatch, err_count increments and saturates at 2^CNT_W-1 with no wrap.
- On a mismatch with first_fail_valid = 0, the block captures idx and sets first_fail_valid. Later failures do not overwrite the capture.
- vec_cnt is VW+1 bits. The run ends on the accept with vec_cnt = N_VEC-1, so there is no wrap inside a run.
- pass = done & (err_count == 0) & ~seq_err, combinational from registers.
- Gaps (in_valid = 0) are allowed anywhere in RUN, of any length.

## Timing
- An accepted vector updates err_count, seq_err and first_fail_* at the next rising edge, so its result is visible 1 cycle after acceptance.
- The last accept moves the FSM to DONE at the same edge. done, pass and final stats are valid together in the first DONE cycle and hold until start or reset.
- busy rises the cycle after start and falls in the same cycle done rises.
- There is no back-pressure: the block accepts in_valid every cycle, so full throughput is 1 vector/clk.
- All outputs are registered except pass, which is a single AND of registered signals.

## Test plan
- **Clean sweep (WIDTH=1):** reset, start, then idx 0..7 back-to-back with a correct adder model.
  - done and pass = 1 the cycle after idx 7.
  - err_count = 0, seq_err = 0, first_fail_valid = 0.
- **Injected faults (WIDTH=1):** force dut_cout = 0 on idx 3 and idx 7, which expect {cout,sum} = 10 and 11.
  - err_count = 2, first_fail_idx = 3'd3, pass = 0, done = 1.
- **Order error (WIDTH=1):** feed 0,1,2,4,3,5,6,7 with correct results.
  - seq_err = 1 from the cycle after the idx-4 accept.
  - err_count = 0, pass = 0.
- **Gaps and restart:** feed 0..4 with random in_valid gaps, pulse start, then feed 0..7 correctly.
  - Stats cleared at the restart.
  - Final pass = 1.
- **Reset mid-run:** assert rst_n = 0 asynchronously between clock edges after idx 5.
  - All outputs are 0 immediately.
  - After release the FSM is in IDLE and in_valid is ignored until start.
- **Saturation (WIDTH=4, CNT_W=4):** N_VEC = 512, every vector wrong.
  - err_count holds 15.
  - first_fail_idx = 0, done = 1 after idx 511.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker
// Consumes the applied {a,b,cin} vectors together with the adder's {sum,cout}.
// It recomputes the expected sum, checks that vectors arrive in ascending
// order, and accumulates run statistics so a sweep can be judged on hardware.
module adder_response_checker #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic               seq_err,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_idx
);

    localparam int VW = 2*WIDTH + 1;
    // Index of the last vector in a sweep (N_VEC-1), held at VW+1 bits so the
    // counter never wraps inside a run.
    localparam logic [VW:0] LAST_IDX = {1'b0, {VW{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // One applied stimulus vector; its packed form is also the sweep index.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } vec_t;

    state_t          state;
    logic [VW:0]     vec_cnt;
    vec_t            cur;
    logic [VW-1:0]   idx;
    logic [WIDTH:0]  exp_res;
    logic [WIDTH:0]  got_res;
    logic            mismatch;
    logic            out_of_order;
    logic            accept;

    assign cur          = '{a: in_a, b: in_b, cin: in_cin};
    assign idx          = cur;
    // Full WIDTH+1 bit result, so the carry-out is checked as well.
    assign exp_res      = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_cin);
    assign got_res      = {dut_cout, dut_sum};
    assign mismatch     = (got_res != exp_res);
    assign out_of_order = ({1'b0, idx} != vec_cnt);
    // start wins over in_valid: a vector arriving with start is dropped.
    assign accept       = (state == S_RUN) && in_valid && !start;

    assign pass = done & (err_count == '0) & ~seq_err;

    // Run-control FSM and statistics, all registered in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            seq_err          <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            vec_cnt          <= '0;
        end else if (start) begin
            // Enter or restart a run from any state with clean statistics.
            state            <= S_RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            err_count        <= '0;
            seq_err          <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            vec_cnt          <= '0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + (VW+1)'(1);
            if (out_of_order)
                seq_err <= 1'b1;
            if (mismatch) begin
                if (err_count != CNT_MAX)
                    err_count <= err_count + CNT_W'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= idx;
                end
            end
            if (vec_cnt == LAST_IDX) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker. A behavioural model of the run
// statistics is advanced as each cycle's stimulus is driven; the expected
// output word is queued then and popped after the clock edge for comparison.
module tb_adder_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, in_a, in_b, in_cin, dut_sum, dut_cout;
    logic       busy, done, pass, seq_err, ffv;
    logic [7:0] err_count;
    logic [2:0] ffi;

    // Second instance for the saturation run.
    logic       s4, v4, cin4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, pass4, seq4, ffv4;
    logic [3:0] err4;
    logic [8:0] ffi4;

    int checks = 0;
    int errors = 0;

    // Model state
    int         m_state;   // 0 idle, 1 run, 2 done
    int         m_cnt;
    int         m_err;
    logic       m_seq, m_ffv;
    logic [2:0] m_ffi;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    adder_response_checker #(.WIDTH(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .seq_err(seq_err), .first_fail_valid(ffv), .first_fail_idx(ffi)
    );

    adder_response_checker #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .in_valid(v4),
        .in_a(a4), .in_b(b4), .in_cin(cin4),
        .dut_sum(sum4), .dut_cout(cout4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .seq_err(seq4), .first_fail_valid(ffv4), .first_fail_idx(ffi4)
    );

    function automatic logic [15:0] obs_word();
        return {busy, done, pass, seq_err, err_count, ffv, ffi};
    endfunction

    function automatic logic [15:0] model_word();
        logic b, d, p;
        b = (m_state == 1);
        d = (m_state == 2);
        p = d && (m_err == 0) && !m_seq;
        return {b, d, p, m_seq, 8'(m_err), m_ffv, m_ffi};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_err = 0;
        m_seq = 1'b0; m_ffv = 1'b0; m_ffi = 3'd0;
    endtask

    // Drive one cycle on the WIDTH=1 instance. bad forces dut_cout to 0.
    task automatic vec(input logic st, input logic v, input logic [2:0] idx,
                       input logic bad, input string tag);
        logic [1:0] r;
        logic       mism;
        r = 2'(idx[2]) + 2'(idx[1]) + 2'(idx[0]);
        start    = st;
        in_valid = v;
        {in_a, in_b, in_cin} = idx;
        dut_sum  = r[0];
        dut_cout = bad ? 1'b0 : r[1];
        mism = ({dut_cout, dut_sum} != r);
        if (st) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1 && v) begin
            if (int'(idx) != m_cnt) m_seq = 1'b1;
            if (mism) begin
                if (m_err < 255) m_err++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffi = idx;
                end
            end
            if (m_cnt == 7) m_state = 2;
            m_cnt++;
        end
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        chk(tag, 32'(obs_word()), 32'(exp_q.pop_front()));
    endtask

    task automatic idle(input string tag);
        vec(1'b0, 1'b0, 3'd0, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; in_valid = 0; in_a = 0; in_b = 0; in_cin = 0;
        dut_sum = 0; dut_cout = 0;
        s4 = 0; v4 = 0; a4 = 0; b4 = 0; cin4 = 0; sum4 = 0; cout4 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs_word()), 32'h0);
        chk("reset_state4", 32'({busy4, done4, pass4, seq4, err4, ffv4, ffi4}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean sweep
        vec(1, 0, 0, 0, "clean_start");
        for (int i = 0; i < 8; i++) vec(0, 1, 3'(i), 0, "clean_vec");
        chk("clean_done", 32'(done), 32'd1);
        chk("clean_pass", 32'(pass), 32'd1);
        idle("clean_hold");

        // Injected faults on idx 3 and 7
        vec(1, 0, 0, 0, "fault_start");
        for (int i = 0; i < 8; i++) vec(0, 1, 3'(i), (i == 3 || i == 7), "fault_vec");
        chk("fault_errcnt", 32'(err_count), 32'd2);
        chk("fault_ffidx", 32'(ffi), 32'd3);
        chk("fault_pass", 32'(pass), 32'd0);

        // Order error: 0,1,2,4,3,5,6,7
        vec(1, 0, 0, 0, "order_start");
        vec(0, 1, 0, 0, "order_vec"); vec(0, 1, 1, 0, "order_vec");
        vec(0, 1, 2, 0, "order_vec"); vec(0, 1, 4, 0, "order_vec4");
        chk("order_seq_after4", 32'(seq_err), 32'd1);
        vec(0, 1, 3, 0, "order_vec");
        for (int i = 5; i < 8; i++) vec(0, 1, 3'(i), 0, "order_vec");
        chk("order_pass", 32'(pass), 32'd0);
        chk("order_errcnt", 32'(err_count), 32'd0);

        // Gaps then restart (start with in_valid drops the vector), with a
        // faulty vector before the restart so clearing is visible.
        vec(1, 0, 0, 0, "gap_start");
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 2)) idle("gap_idle");
            vec(0, 1, 3'(i), (i == 1), "gap_vec");
        end
        vec(1, 1, 5, 0, "restart_drop");
        chk("restart_cleared", 32'({err_count, ffv}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) idle("gap_idle2");
            vec(0, 1, 3'(i), 0, "restart_vec");
        end
        chk("restart_pass", 32'(pass), 32'd1);

        // Reset mid-run after idx 5
        vec(1, 0, 0, 0, "rst_start");
        for (int i = 0; i < 6; i++) vec(0, 1, 3'(i), (i == 2), "rst_vec");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_clear", 32'(obs_word()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec(0, 1, 0, 1, "rst_idle_ignore");
        vec(0, 1, 1, 1, "rst_idle_ignore");
        vec(1, 0, 0, 0, "rst_restart");
        for (int i = 0; i < 8; i++) vec(0, 1, 3'(i), 0, "rst_sweep");
        chk("rst_final_pass", 32'(pass), 32'd1);

        // Saturation on WIDTH=4, CNT_W=4: every vector wrong
        s4 = 1'b1;
        @(posedge clk);
        #1;
        s4 = 1'b0;
        v4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [4:0] r;
            logic [8:0] ix;
            ix = 9'(i);
            {a4, b4, cin4} = ix;
            r = 5'(a4) + 5'(b4) + 5'(cin4);
            {cout4, sum4} = ~r;
            @(posedge clk);
            #1;
            if (i == 14) chk("sat_reach15", 32'(err4), 32'd15);
            if (i == 15) chk("sat_nowrap", 32'(err4), 32'd15);
            if (i == 510) chk("sat_not_done", 32'(done4), 32'd0);
        end
        v4 = 1'b0;
        chk("sat_errcnt", 32'(err4), 32'd15);
        chk("sat_ffidx", 32'({ffv4, ffi4}), 32'h200);
        chk("sat_done", 32'({busy4, done4, pass4}), 32'b010);
        @(posedge clk);
        #1;
        chk("sat_hold", 32'({done4, err4}), 32'h1f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
